// File: rtl/spi_peripheral.sv
// SPI mode-0 target. The controller's cs/sck/sdi are oversampled on clk
// through two-flop synchronizers; a third flop on cs and sck gives edge
// strobes. A frame shifts rx bits in on sck rise and tx bits out on sck
// fall. A frame with exactly RX_WIDTH bits updates rx_data with an
// rx_valid pulse. Any other bit count gives a frame_err pulse instead.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for a cs fall; sdo held at 0
// ST_ACTIVE | frame in progress; shifting on sck edges, sdo driven
// ST_DONE   | cs has risen; one cycle to judge the bit count
module spi_peripheral #(
   parameter int TX_WIDTH = 24,
   parameter int RX_WIDTH = 24
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic                cs,
   input  logic                sck,
   input  logic                sdi,
   output logic                sdo,
   output logic                sdo_oe,
   input  logic [TX_WIDTH-1:0] tx_data,
   output logic [RX_WIDTH-1:0] rx_data,
   output logic                rx_valid,
   output logic                frame_err,
   output logic                busy
);

   localparam int CW = $clog2(RX_WIDTH + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(RX_WIDTH);
   // Saturating one past full makes any over-long frame look wrong.
   localparam logic [CW-1:0] CNT_SAT  = CW'(RX_WIDTH + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE} state_t;

   state_t              state_q, state_d;
   logic                cs_s1_q, cs_s2_q, cs_s3_q;
   logic                cs_s1_d, cs_s2_d, cs_s3_d;
   logic                sck_s1_q, sck_s2_q, sck_s3_q;
   logic                sck_s1_d, sck_s2_d, sck_s3_d;
   logic                sdi_s1_q, sdi_s2_q;
   logic                sdi_s1_d, sdi_s2_d;
   logic [TX_WIDTH-1:0] tx_buf_q, tx_buf_d;
   logic [RX_WIDTH-1:0] rx_buf_q, rx_buf_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [RX_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                rx_valid_q, rx_valid_d;
   logic                frame_err_q, frame_err_d;

   logic cs_rise, cs_fall, sck_rise, sck_fall;

   // Edge strobes from the synchronized pins; sdi_s2_q lines up with sck_rise.
   always_comb begin
      cs_rise  =  cs_s2_q  & ~cs_s3_q;
      cs_fall  = ~cs_s2_q  &  cs_s3_q;
      sck_rise =  sck_s2_q & ~sck_s3_q;
      sck_fall = ~sck_s2_q &  sck_s3_q;
   end

   // Next-state logic for the synchronizers, frame FSM and shift registers.
   always_comb begin
      cs_s1_d     = cs;
      cs_s2_d     = cs_s1_q;
      cs_s3_d     = cs_s2_q;
      sck_s1_d    = sck;
      sck_s2_d    = sck_s1_q;
      sck_s3_d    = sck_s2_q;
      sdi_s1_d    = sdi;
      sdi_s2_d    = sdi_s1_q;
      state_d     = state_q;
      tx_buf_d    = tx_buf_q;
      rx_buf_d    = rx_buf_q;
      cnt_d       = cnt_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d  = ST_ACTIVE;
               tx_buf_d = tx_data;
               rx_buf_d = '0;
               cnt_d    = '0;
            end
         end
         ST_ACTIVE: begin
            // A cs rise wins over any sck edge strobed in the same cycle.
            if (cs_rise) begin
               state_d  = ST_DONE;
               tx_buf_d = '0;
            end else if (sck_rise) begin
               rx_buf_d = {rx_buf_q[RX_WIDTH-2:0], sdi_s2_q};
               if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
            end else if (sck_fall) begin
               tx_buf_d = {tx_buf_q[TX_WIDTH-2:0], 1'b0};
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            if (cnt_q == CNT_FULL) begin
               rx_data_d  = rx_buf_q;
               rx_valid_d = 1'b1;
            end else begin
               frame_err_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // All state registered here; cs synchronizer resets high so reset reads as deselected.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         cs_s1_q     <= 1'b1;
         cs_s2_q     <= 1'b1;
         cs_s3_q     <= 1'b1;
         sck_s1_q    <= 1'b0;
         sck_s2_q    <= 1'b0;
         sck_s3_q    <= 1'b0;
         sdi_s1_q    <= 1'b0;
         sdi_s2_q    <= 1'b0;
         state_q     <= ST_IDLE;
         tx_buf_q    <= '0;
         rx_buf_q    <= '0;
         cnt_q       <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         cs_s1_q     <= cs_s1_d;
         cs_s2_q     <= cs_s2_d;
         cs_s3_q     <= cs_s3_d;
         sck_s1_q    <= sck_s1_d;
         sck_s2_q    <= sck_s2_d;
         sck_s3_q    <= sck_s3_d;
         sdi_s1_q    <= sdi_s1_d;
         sdi_s2_q    <= sdi_s2_d;
         state_q     <= state_d;
         tx_buf_q    <= tx_buf_d;
         rx_buf_q    <= rx_buf_d;
         cnt_q       <= cnt_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   // tx_buf is zero outside ACTIVE, so sdo idles low without extra gating.
   always_comb begin
      sdo       = tx_buf_q[TX_WIDTH-1];
      busy      = (state_q == ST_ACTIVE);
      sdo_oe    = (state_q == ST_ACTIVE);
      rx_data   = rx_data_q;
      rx_valid  = rx_valid_q;
      frame_err = frame_err_q;
   end

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: a task-level SPI controller at fclk/8,
// a scoreboard queue of expected frame outcomes, and a monitor that pops
// the queue on every rx_valid / frame_err pulse.
module tb_spi_peripheral;
   localparam int W = 24;

   logic         clk = 1'b0;
   logic         nrst, cs, sck, sdi;
   logic         sdo, sdo_oe, rx_valid, frame_err, busy;
   logic [W-1:0] tx_data, rx_data;

   int checks   = 0;
   int failures = 0;
   bit mon_en   = 1'b0;

   typedef struct {
      bit           is_err;
      logic [W-1:0] data;
   } ev_t;
   ev_t          sb_q[$];
   logic [W-1:0] last_good;

   always #5 clk = ~clk;

   spi_peripheral #(.TX_WIDTH(W), .RX_WIDTH(W)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .cs        (cs),
      .sck       (sck),
      .sdi       (sdi),
      .sdo       (sdo),
      .sdo_oe    (sdo_oe),
      .tx_data   (tx_data),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Every result pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (mon_en && (rx_valid || frame_err)) begin
         ev_t e;
         chk("pulse_overlap", W'(rx_valid & frame_err), '0);
         chk("event_expected", W'(sb_q.size() != 0), W'(1));
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("event_kind", W'(frame_err), W'(e.is_err));
            if (!e.is_err) chk("rx_word", rx_data, e.data);
         end
      end
   end

   task automatic begin_frame(input logic [W-1:0] txw, input int nbits, input logic [W-1:0] rxw);
      ev_t e;
      e.is_err = (nbits != W);
      e.data   = rxw;
      sb_q.push_back(e);
      if (!e.is_err) last_good = rxw;
      tx_data = txw;
      clks(4);
      cs = 1'b0;
      clks(4);
   endtask

   // Bits first..last of a frame; txoff is the bit index where the DUT loaded tx_data.
   task automatic send_bits(input logic [W-1:0] rxw, input logic [W-1:0] txw,
                            input int first, input int last, input int txoff);
      logic exp_sdo;
      for (int i = first; i <= last; i++) begin
         sdi = 1'b0;
         if (i < W) sdi = rxw[W-1-i];
         clks(4);
         sck = 1'b1;
         exp_sdo = 1'b0;
         if (i - txoff < W) exp_sdo = txw[W-1-(i-txoff)];
         chk($sformatf("sdo_bit%0d", i), W'(sdo), W'(exp_sdo));
         chk("busy_in_frame", W'({busy, sdo_oe}), W'(2'b11));
         clks(4);
         sck = 1'b0;
      end
   endtask

   task automatic end_frame();
      clks(4);
      cs = 1'b1;
   endtask

   task automatic settle(input string tag);
      clks(8);
      chk({tag, "_pending"}, W'(sb_q.size()), '0);
      chk({tag, "_rx_data"}, rx_data, last_good);
      chk({tag, "_idle"}, W'({busy, sdo_oe, sdo}), '0);
   endtask

   initial begin
      nrst = 1'b0; cs = 1'b1; sck = 1'b0; sdi = 1'b0; tx_data = '0; last_good = '0;
      clks(3);
      chk("rst_outs", W'({sdo, sdo_oe, busy, rx_valid, frame_err}), '0);
      chk("rst_rx_data", rx_data, '0);
      nrst = 1'b1;
      mon_en = 1'b1;
      clks(4);

      // nominal frame
      begin_frame(24'hA5C3F0, 24, 24'h123456);
      send_bits(24'h123456, 24'hA5C3F0, 0, 23, 0);
      end_frame();
      settle("nominal");

      // short frame: 23 bits
      begin_frame(24'h0F0F0F, 23, 24'h654321);
      send_bits(24'h654321, 24'h0F0F0F, 0, 22, 0);
      end_frame();
      settle("short");

      // long frame: 26 bits, zeros after the word
      begin_frame(24'hFFFFFF, 26, 24'h777777);
      send_bits(24'h777777, 24'hFFFFFF, 0, 25, 0);
      end_frame();
      settle("long");

      // back-to-back frames, 4 clk cs high between them
      begin_frame(24'h111111, 24, 24'h000001);
      send_bits(24'h000001, 24'h111111, 0, 23, 0);
      end_frame();
      begin_frame(24'h3C3C3C, 24, 24'h800000);
      send_bits(24'h800000, 24'h3C3C3C, 0, 23, 0);
      end_frame();
      settle("b2b");

      // reset after bit 10; controller keeps cs low and finishes 14 bits
      begin_frame(24'h5A5A5A, 24, 24'hC0FFEE);
      send_bits(24'hC0FFEE, 24'h5A5A5A, 0, 9, 0);
      void'(sb_q.pop_back());
      last_good = 24'h000000;
      nrst = 1'b0;
      clks(1);
      chk("midrst_outs", W'({sdo, sdo_oe, busy, rx_valid, frame_err}), '0);
      chk("midrst_rx_data", rx_data, '0);
      clks(1);
      nrst = 1'b1;
      begin
         ev_t e;
         e.is_err = 1'b1;
         e.data   = '0;
         sb_q.push_back(e);
      end
      send_bits(24'hC0FFEE, 24'h5A5A5A, 10, 23, 10);
      end_frame();
      settle("midrst");

      begin_frame(24'h13579B, 24, 24'hABCDEF);
      send_bits(24'hABCDEF, 24'h13579B, 0, 23, 0);
      end_frame();
      settle("after_rst");

      // sck noise with cs high
      for (int i = 0; i < 8; i++) begin
         sck = 1'b1;
         clks(4);
         chk("noise_idle_hi", W'({busy, sdo_oe}), '0);
         sck = 1'b0;
         clks(4);
         chk("noise_idle_lo", W'({busy, sdo_oe}), '0);
      end
      settle("noise");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
